// File: rtl/clint_if.sv
`default_nettype none
// ============================================================================
// Module   : clint_if
// Purpose  : Data-bus connection between the core (master) and the CLINT
//            responder (slave). There is one request strobe and a response
//            that follows it with fixed one-cycle latency.
// Signals  : clint_valid  - request strobe (master -> slave)
//            clint_instr  - instruction-fetch flag (master -> slave)
//            clint_addr   - byte address (master -> slave)
//            clint_wdata  - write data (master -> slave)
//            clint_wstrb  - byte write enables, 0 = read (master -> slave)
//            clint_rdata  - read data (slave -> master)
//            clint_ready  - response strobe (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface clint_if;
    logic        clint_valid;
    logic        clint_instr;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;

    modport master (
        output clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
        input  clint_rdata, clint_ready
    );

    modport slave (
        input  clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
        output clint_rdata, clint_ready
    );
endinterface
`default_nettype wire

// File: rtl/clint_responder.sv
`default_nettype none
// ============================================================================
// Module   : clint_responder
// Purpose  : Core-local interruptor. It holds mtime (ticked by an internally
//            divided RTC), mtimecmp and msip. It drives the machine timer and
//            software interrupt lines and answers bus requests after one cycle.
// Ports    : clock        - core clock
//            reset        - synchronous, active-low reset
//            bus          - clint_if.slave request/response bus
//            clint_msip   - machine software interrupt pending
//            clint_mtip   - machine timer interrupt pending (registered)
//            clint_mtime  - current mtime value
// Config   : CLINT_MTIME_WRITE_EN - when defined, mtime is writable over the
//            bus. A write in a tick cycle wins, and that tick is lost.
// Revision : 1.0 - initial release
// ============================================================================
module clint_responder #(
    parameter int unsigned CLK_DIVIDER_RTC = 4,
    parameter logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  wire logic   clock,
    input  wire logic   reset,
    clint_if.slave      bus,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

`ifdef CLINT_MTIME_WRITE_EN
    localparam bit c_MTIME_WRITABLE = 1'b1;
`else
    localparam bit c_MTIME_WRITABLE = 1'b0;
`endif

    localparam int unsigned        c_CNT_W = (CLK_DIVIDER_RTC < 1) ? 1 : $clog2(CLK_DIVIDER_RTC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIVIDER_RTC);

    // Word indices (byte offset >> 2) of the mapped registers
    localparam logic [13:0] c_WORD_MSIP     = 14'h0000;
    localparam logic [13:0] c_WORD_MTCMP_LO = 14'h1000;
    localparam logic [13:0] c_WORD_MTCMP_HI = 14'h1001;
    localparam logic [13:0] c_WORD_MTIME_LO = 14'h2FFE;
    localparam logic [13:0] c_WORD_MTIME_HI = 14'h2FFF;

    logic [c_CNT_W-1:0] r_count;
    logic               r_rtc;
    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic               r_msip;
    logic               r_mtip;
    logic               r_ready;
    logic [31:0]        r_rdata;

    logic [13:0]        w_word;
    logic               w_wr;
    logic               w_rtc_wrap;
    logic               w_tick;
    logic [31:0]        w_rd_data;
    logic [63:0]        w_mtime_next;
    logic [63:0]        w_mtimecmp_next;
    logic               w_msip_next;
    logic               w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign w_word     = bus.clint_addr[15:2];
    assign w_wr       = bus.clint_valid && (bus.clint_wstrb != 4'b0000);
    assign w_rtc_wrap = (r_count == c_CNT_MAX);
    // mtime advances on the rising edge of the divided RTC.
    assign w_tick     = w_rtc_wrap && !r_rtc;

    // The fetch flag and the address bits outside [15:2] play no part in decoding.
    assign w_unused   = &{1'b0, bus.clint_instr, bus.clint_addr[31:16], bus.clint_addr[1:0]};

    // Read data comes from the register values before any write in this cycle.
    always_comb begin
        w_rd_data = 32'h0;
        case (w_word)
            c_WORD_MSIP:     w_rd_data = {31'h0, r_msip};
            c_WORD_MTCMP_LO: w_rd_data = r_mtimecmp[31:0];
            c_WORD_MTCMP_HI: w_rd_data = r_mtimecmp[63:32];
            c_WORD_MTIME_LO: w_rd_data = r_mtime[31:0];
            c_WORD_MTIME_HI: w_rd_data = r_mtime[63:32];
            default:         w_rd_data = 32'h0;
        endcase
    end

    always_comb begin
        w_msip_next     = r_msip;
        w_mtimecmp_next = r_mtimecmp;
        w_mtime_next    = w_tick ? (r_mtime + 64'd1) : r_mtime;
        if (w_wr) begin
            case (w_word)
                c_WORD_MSIP: begin
                    if (bus.clint_wstrb[0]) w_msip_next = bus.clint_wdata[0];
                end
                c_WORD_MTCMP_LO: w_mtimecmp_next[31:0] =
                    f_merge(r_mtimecmp[31:0], bus.clint_wdata, bus.clint_wstrb);
                c_WORD_MTCMP_HI: w_mtimecmp_next[63:32] =
                    f_merge(r_mtimecmp[63:32], bus.clint_wdata, bus.clint_wstrb);
                // A bus write replaces the whole register, including any tick in the same cycle.
                c_WORD_MTIME_LO: begin
                    if (c_MTIME_WRITABLE)
                        w_mtime_next = {r_mtime[63:32],
                                        f_merge(r_mtime[31:0], bus.clint_wdata, bus.clint_wstrb)};
                end
                c_WORD_MTIME_HI: begin
                    if (c_MTIME_WRITABLE)
                        w_mtime_next = {f_merge(r_mtime[63:32], bus.clint_wdata, bus.clint_wstrb),
                                        r_mtime[31:0]};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count    <= '0;
            r_rtc      <= 1'b0;
            r_mtime    <= 64'h0;
            r_mtimecmp <= MTIMECMP_RESET;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
            r_ready    <= 1'b0;
            r_rdata    <= 32'h0;
        end else begin
            if (w_rtc_wrap) begin
                r_count <= '0;
                r_rtc   <= ~r_rtc;
            end else begin
                r_count <= r_count + 1'b1;
            end
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_mtimecmp_next;
            r_msip     <= w_msip_next;
            r_mtip     <= (r_mtime >= r_mtimecmp);
            r_ready    <= bus.clint_valid;
            r_rdata    <= bus.clint_valid ? w_rd_data : 32'h0;
        end
    end

    assign bus.clint_ready = r_ready;
    assign bus.clint_rdata = r_rdata;
    assign clint_msip      = r_msip;
    assign clint_mtip      = r_mtip;
    assign clint_mtime     = r_mtime;

endmodule
`default_nettype wire

// File: tb/tb_clint_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint_responder
// Purpose  : Self-checking bench for clint_responder. A behavioural model
//            derives mtime from the number of clocks since reset release. The
//            model's outputs are compared on every falling edge. Directed
//            scenarios with literal expectations are followed by randomized
//            traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint_responder;
    localparam int c_DIV    = 4;
    localparam int c_PERIOD = 2 * (c_DIV + 1);   // clocks between mtime ticks
    localparam int c_FIRST  = c_DIV + 1;         // first tick after reset release

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    clint_if bus_if ();

    clint_responder #(
        .CLK_DIVIDER_RTC (c_DIV),
        .MTIMECMP_RESET  (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus_if),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic        m_mtip;
    logic        m_ready;
    logic [31:0] m_rdata;
    int unsigned m_edges;   // clock edges seen with reset released

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge clock) begin : model
        logic [63:0] t_mtime;
        logic [63:0] t_cmp;
        logic        t_msip;
        logic [31:0] t_rd;
        logic        t_tick;
        logic [15:0] off;
        int unsigned e;
        if (!reset) begin
            m_mtime <= 64'h0;
            m_cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip  <= 1'b0;
            m_mtip  <= 1'b0;
            m_ready <= 1'b0;
            m_rdata <= 32'h0;
            m_edges <= 0;
        end else begin
            e      = m_edges + 1;
            t_tick = (e >= c_FIRST) && (((e - c_FIRST) % c_PERIOD) == 0);
            off    = {bus_if.clint_addr[15:2], 2'b00};
            case (off)
                16'h0000: t_rd = {31'h0, m_msip};
                16'h4000: t_rd = m_cmp[31:0];
                16'h4004: t_rd = m_cmp[63:32];
                16'hBFF8: t_rd = m_mtime[31:0];
                16'hBFFC: t_rd = m_mtime[63:32];
                default:  t_rd = 32'h0;
            endcase
            t_mtime = t_tick ? m_mtime + 64'd1 : m_mtime;
            t_cmp   = m_cmp;
            t_msip  = m_msip;
            if (bus_if.clint_valid && bus_if.clint_wstrb != 4'h0) begin
                case (off)
                    16'h0000: if (bus_if.clint_wstrb[0]) t_msip = bus_if.clint_wdata[0];
                    16'h4000: t_cmp[31:0]  = merge(m_cmp[31:0], bus_if.clint_wdata, bus_if.clint_wstrb);
                    16'h4004: t_cmp[63:32] = merge(m_cmp[63:32], bus_if.clint_wdata, bus_if.clint_wstrb);
`ifdef CLINT_MTIME_WRITE_EN
                    16'hBFF8: t_mtime = {m_mtime[63:32], merge(m_mtime[31:0], bus_if.clint_wdata, bus_if.clint_wstrb)};
                    16'hBFFC: t_mtime = {merge(m_mtime[63:32], bus_if.clint_wdata, bus_if.clint_wstrb), m_mtime[31:0]};
`endif
                    default: ;
                endcase
            end
            m_mtip  <= (m_mtime >= m_cmp);
            m_mtime <= t_mtime;
            m_cmp   <= t_cmp;
            m_msip  <= t_msip;
            m_ready <= bus_if.clint_valid;
            m_rdata <= bus_if.clint_valid ? t_rd : 32'h0;
            m_edges <= e;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        chk("cyc_ready", {63'h0, bus_if.clint_ready}, {63'h0, m_ready});
        chk("cyc_rdata", {32'h0, bus_if.clint_rdata}, {32'h0, m_rdata});
        chk("cyc_msip",  {63'h0, clint_msip},         {63'h0, m_msip});
        chk("cyc_mtip",  {63'h0, clint_mtip},         {63'h0, m_mtip});
        chk("cyc_mtime", clint_mtime,                 m_mtime);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic rst_n);
        @(posedge clock);
        #1;
        reset              = rst_n;
        bus_if.clint_valid = v;
        bus_if.clint_instr = 1'($urandom_range(0, 1));
        bus_if.clint_addr  = a;
        bus_if.clint_wdata = d;
        bus_if.clint_wstrb = s;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        drive(1'b1, a, d, s, 1'b1);
    endtask

    task automatic wait_mtime(input logic [63:0] v, input int bound);
        int k;
        k = 0;
        while (clint_mtime != v && k < bound) begin
            idle();
            k++;
        end
        chk("wait_mtime_timeout", {63'h0, (clint_mtime != v)}, 64'h0);
    endtask

    logic [63:0] pre;
    logic [31:0] rd1, rd2, rd3;
    logic        rdy1, rdy2, rdy3;

    initial begin
        bus_if.clint_valid = 1'b0;
        bus_if.clint_instr = 1'b0;
        bus_if.clint_addr  = 32'h0;
        bus_if.clint_wdata = 32'h0;
        bus_if.clint_wstrb = 4'h0;
        reset = 1'b0;
        repeat (3) drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        chk("reset_ready", {63'h0, bus_if.clint_ready}, 64'h0);
        chk("reset_rdata", {32'h0, bus_if.clint_rdata}, 64'h0);
        chk("reset_mtime", clint_mtime, 64'h0);
        chk("reset_mtip",  {63'h0, clint_mtip}, 64'h0);
        chk("reset_msip",  {63'h0, clint_msip}, 64'h0);

        // Release reset; the next edge is clock 1.
        idle();
        repeat (4) idle();
        chk("mtime_clk4", clint_mtime, 64'd0);
        idle();
        chk("mtime_clk5", clint_mtime, 64'd1);
        repeat (9) idle();
        chk("mtime_clk14", clint_mtime, 64'd1);
        idle();
        chk("mtime_clk15", clint_mtime, 64'd2);
        repeat (10) idle();
        chk("mtime_clk25", clint_mtime, 64'd3);
        chk("idle_mtip", {63'h0, clint_mtip}, 64'h0);
        chk("idle_msip", {63'h0, clint_msip}, 64'h0);

        // msip set/clear
        req(32'h0200_0000, 32'h1, 4'hF);
        idle();
        chk("msip_ready", {63'h0, bus_if.clint_ready}, 64'h1);
        chk("msip_set",   {63'h0, clint_msip}, 64'h1);
        req(32'h0200_0000, 32'h0, 4'hF);
        idle();
        chk("msip_clr",   {63'h0, clint_msip}, 64'h0);

        // mtimecmp = 3 -> mtip; hi = all ones -> mtip clears
        req(32'h0200_4000, 32'h3, 4'hF);
        req(32'h0200_4004, 32'h0, 4'hF);
        idle();
        chk("mtip_lag", {63'h0, clint_mtip}, 64'h0);
        idle();
        chk("mtip_set", {63'h0, clint_mtip}, 64'h1);
        req(32'h0200_4004, 32'hFFFF_FFFF, 4'hF);
        idle();
        chk("mtip_hold", {63'h0, clint_mtip}, 64'h1);
        idle();
        chk("mtip_clr", {63'h0, clint_mtip}, 64'h0);

        // mtime read and unmapped read
        wait_mtime(64'd7, 200);
        req(32'h0200_BFF8, 32'h0, 4'h0);
        idle();
        chk("rd_mtime_ready", {63'h0, bus_if.clint_ready}, 64'h1);
        chk("rd_mtime_data",  {32'h0, bus_if.clint_rdata}, 64'd7);
        req(32'h0200_1000, 32'hDEAD_BEEF, 4'h0);
        idle();
        chk("rd_unmapped_ready", {63'h0, bus_if.clint_ready}, 64'h1);
        chk("rd_unmapped_data",  {32'h0, bus_if.clint_rdata}, 64'h0);
        req(32'h0200_1000, 32'hDEAD_BEEF, 4'hF);
        idle();

        // mtime write / wrap
        pre = clint_mtime;
        req(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF);
        req(32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF);
        idle();
`ifdef CLINT_MTIME_WRITE_EN
        chk("mtime_written", clint_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_mtime(64'h0, 12);
        chk("mtime_wrap", clint_mtime, 64'h0);
`else
        chk("mtime_hi_untouched", {32'h0, clint_mtime[63:32]}, 64'h0);
        chk("mtime_unaffected", {63'h0, (clint_mtime == pre || clint_mtime == pre + 64'd1)}, 64'h1);
`endif

        // back-to-back read / write / read of mtimecmp lo
        req(32'h0200_4000, 32'hFFFF_FFFF, 4'hF);
        req(32'h0200_4000, 32'h55, 4'h0);
        req(32'h0200_4000, 32'h55, 4'h1);
        rdy1 = bus_if.clint_ready; rd1 = bus_if.clint_rdata;
        req(32'h0200_4000, 32'h55, 4'h0);
        rdy2 = bus_if.clint_ready; rd2 = bus_if.clint_rdata;
        idle();
        rdy3 = bus_if.clint_ready; rd3 = bus_if.clint_rdata;
        chk("b2b_ready1", {63'h0, rdy1}, 64'h1);
        chk("b2b_rdata1", {32'h0, rd1}, 64'hFFFF_FFFF);
        chk("b2b_ready2", {63'h0, rdy2}, 64'h1);
        chk("b2b_rdata2", {32'h0, rd2}, 64'hFFFF_FFFF);
        chk("b2b_ready3", {63'h0, rdy3}, 64'h1);
        chk("b2b_rdata3", {32'h0, rd3}, 64'hFFFF_FF55);

        // reset while a request is presented
        req(32'h0200_0000, 32'h1, 4'hF);
        drive(1'b1, 32'h0200_4000, 32'h0, 4'h0, 1'b0);
        idle();
        chk("rst_req_ready", {63'h0, bus_if.clint_ready}, 64'h0);
        chk("rst_req_rdata", {32'h0, bus_if.clint_rdata}, 64'h0);
        chk("rst_req_msip",  {63'h0, clint_msip}, 64'h0);
        chk("rst_req_mtime", clint_mtime, 64'h0);
        req(32'h0200_4000, 32'h0, 4'h0);
        idle();
        chk("rst_cmp_lo", {32'h0, bus_if.clint_rdata}, 64'hFFFF_FFFF);
        req(32'h0200_4004, 32'h0, 4'h0);
        idle();
        chk("rst_cmp_hi", {32'h0, bus_if.clint_rdata}, 64'hFFFF_FFFF);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            logic        v;
            logic        r;
            case ($urandom_range(0, 5))
                0: a = 32'h0200_0000;
                1: a = 32'h0200_4000;
                2: a = 32'h0200_4004;
                3: a = 32'h0200_BFF8;
                4: a = 32'h0200_BFFC;
                default: a = $urandom;
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 120)) : $urandom;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            v = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 199) != 0);
            drive(v, a, d, s, r);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
